// File: rtl/herculesae_vx_sha1sched.sv
// -----------------------------------------------------------------------------
// herculesae_vx_sha1sched
//
// SHA-1 message-schedule / round-feed engine. Accepts one 512-bit message block
// and then streams the 80 round words t2 = W[t] + K[t] (mod 2^32) to a round
// consumer over a valid/ready handshake. Each word carries a one-hot round
// function select (choose / parity / majority) and cpm = 1.
//
// The schedule expansion W[16..79] is done in place in a 16-entry circular
// buffer: the word produced for round t overwrites slot t%16 when it is
// consumed, which is exactly the slot that round t+16 will need as W[t].
//
// Ports
//   clk         in   1    clock, all state on rising edge
//   reset_n     in   1    asynchronous active-low reset
//   blk_valid   in   1    message block offered
//   blk_ready   out  1    engine can accept a block (IDLE)
//   blk_data    in   512  W[i] = blk_data[32*i+31:32*i], i = 0..15
//   flush       in   1    synchronous abort of the current block
//   w_valid     out  1    round word valid
//   w_ready     in   1    consumer accepts round word
//   w_t2        out  32   W[t] + K[t] mod 2^32
//   w_round     out  7    round index t
//   w_choose    out  1    round function select, t in 0..19
//   w_parity    out  1    round function select, t in 20..39 or 60..79
//   w_majority  out  1    round function select, t in 40..59
//   w_cpm       out  1    equals w_valid
//   w_last      out  1    w_valid and t == 79
// -----------------------------------------------------------------------------
module herculesae_vx_sha1sched #(
    parameter logic [31:0] K0 = 32'h5A827999,
    parameter logic [31:0] K1 = 32'h6ED9EBA1,
    parameter logic [31:0] K2 = 32'h8F1BBCDC,
    parameter logic [31:0] K3 = 32'hCA62C1D6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         flush,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_t2,
    output logic [6:0]   w_round,
    output logic         w_choose,
    output logic         w_parity,
    output logic         w_majority,
    output logic         w_cpm,
    output logic         w_last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  t_q, t_d;

    logic [31:0] buf_q [16];

    logic [3:0]  ptr;
    logic [3:0]  ptr_m3, ptr_m8, ptr_m14;
    logic [31:0] mix;
    logic [31:0] w_cur;
    logic [31:0] k_cur;
    logic        is_run;
    logic        load_blk;
    logic        wr_en;

    // Pointer arithmetic wraps naturally in 4 bits (mod 16).
    assign ptr     = t_q[3:0];
    assign ptr_m3  = ptr - 4'd3;
    assign ptr_m8  = ptr - 4'd8;
    assign ptr_m14 = ptr - 4'd14;

    // Slot ptr still holds W[t-16] here; it becomes W[t] once consumed.
    assign mix   = buf_q[ptr_m3] ^ buf_q[ptr_m8] ^ buf_q[ptr_m14] ^ buf_q[ptr];
    assign w_cur = (t_q < 7'd16) ? buf_q[ptr] : {mix[30:0], mix[31]};

    always_comb begin
        k_cur = K3;
        if (t_q < 7'd20) begin
            k_cur = K0;
        end else if (t_q < 7'd40) begin
            k_cur = K1;
        end else if (t_q < 7'd60) begin
            k_cur = K2;
        end
    end

    assign is_run   = (state_q == RUN);
    // flush wins over both handshakes: no load, no buffer write.
    assign load_blk = (state_q == IDLE) & blk_valid & ~flush;
    assign wr_en    = is_run & w_ready & ~flush;

    // -------------------------------------------------------------------------
    // Circular W buffer, one register per slot.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_buf
            logic [31:0] entry_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_q <= 32'd0;
                end else if (load_blk) begin
                    entry_q <= blk_data[32*gi +: 32];
                end else if (wr_en && (ptr == 4'(gi))) begin
                    entry_q <= w_cur;
                end
            end

            assign buf_q[gi] = entry_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= 7'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        if (flush) begin
            state_d = IDLE;
            t_d     = 7'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blk_valid) begin
                        state_d = RUN;
                        t_d     = 7'd0;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        if (t_q == 7'd79) begin
                            state_d = IDLE;
                            t_d     = 7'd0;
                        end else begin
                            t_d = t_q + 7'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    t_d     = 7'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: functions of registered state only.
    // -------------------------------------------------------------------------
    always_comb begin
        blk_ready  = (state_q == IDLE);
        w_valid    = is_run;
        w_cpm      = is_run;
        w_round    = t_q;
        w_t2       = 32'd0;
        w_choose   = 1'b0;
        w_parity   = 1'b0;
        w_majority = 1'b0;
        w_last     = 1'b0;
        if (is_run) begin
            w_t2       = w_cur + k_cur;
            w_choose   = (t_q < 7'd20);
            w_majority = (t_q >= 7'd40) && (t_q < 7'd60);
            w_parity   = ~w_choose & ~w_majority;
            w_last     = (t_q == 7'd79);
        end
    end

endmodule

// File: tb/tb_herculesae_vx_sha1sched.sv
module tb_herculesae_vx_sha1sched;

    logic         clk;
    logic         reset_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         flush;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_t2;
    logic [6:0]   w_round;
    logic         w_choose;
    logic         w_parity;
    logic         w_majority;
    logic         w_cpm;
    logic         w_last;

    int checks = 0;
    int errors = 0;

    herculesae_vx_sha1sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .flush      (flush),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_t2       (w_t2),
        .w_round    (w_round),
        .w_choose   (w_choose),
        .w_parity   (w_parity),
        .w_majority (w_majority),
        .w_cpm      (w_cpm),
        .w_last     (w_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straight-line SHA-1 schedule over a full 80-entry array.
    function automatic logic [31:0] exp_t2(input logic [511:0] b, input int t);
        logic [31:0] w [80];
        logic [31:0] x;
        logic [31:0] k;
        for (int i = 0; i < 16; i++) w[i] = b[32*i +: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        if (t < 20)      k = 32'h5A827999;
        else if (t < 40) k = 32'h6ED9EBA1;
        else if (t < 60) k = 32'h8F1BBCDC;
        else             k = 32'hCA62C1D6;
        return w[t] + k;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Entered at a negedge in IDLE; returns at the negedge where t=0 is presented.
    task automatic offer(input logic [511:0] b);
        int g = 0;
        blk_data  = b;
        blk_valid = 1'b1;
        while (!blk_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!blk_ready) $display("FAIL offer_timeout blk_ready=%b required=1", blk_ready);
        if (!blk_ready) errors++;
        @(negedge clk);
        blk_valid = 1'b0;
        $display("block accepted at %0t", $time);
    endtask

    // Consumes rounds t_first..t_end-1, checking every presented word.
    task automatic stream_words(input logic [511:0] b, input int t_first,
                                input int t_end, input bit stall);
        int t = t_first;
        int guard = 0;
        bit prev_stall = 1'b0;
        logic [44:0] obs, prev_obs;
        logic [4:0]  sel_exp, sel_obs;
        prev_obs = '0;
        while (t < t_end && guard < 1000) begin
            obs = {w_valid, w_t2, w_round, w_choose, w_parity, w_majority, w_cpm, w_last};
            if (prev_stall) begin
                checks++;
                if (obs !== prev_obs) begin
                    $display("FAIL stall_hold t=%0d got=%h required=%h", t, obs, prev_obs);
                    errors++;
                end
            end
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_t2 !== exp_t2(b, t)) begin
                $display("FAIL word t=%0d got valid=%b round=%0d t2=%h required valid=1 round=%0d t2=%h",
                         t, w_valid, w_round, w_t2, t, exp_t2(b, t));
                errors++;
            end
            sel_exp = {t < 20, (t >= 20 && t < 40) || t >= 60, t >= 40 && t < 60, 1'b1, t == 79};
            sel_obs = {w_choose, w_parity, w_majority, w_cpm, w_last};
            checks++;
            if (sel_obs !== sel_exp) begin
                $display("FAIL select t=%0d got=%b required=%b", t, sel_obs, sel_exp);
                errors++;
            end
            w_ready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = !w_ready;
            prev_obs   = obs;
            if (w_ready) t++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (t < t_end) begin
            $display("FAIL stream_timeout reached t=%0d required=%0d", t, t_end);
            errors++;
        end
        if (t_end == 80) begin
            w_ready = 1'b0;
            checks++;
            if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_last !== 1'b0 || w_round !== 7'd0) begin
                $display("FAIL end_idle got valid=%b ready=%b last=%b round=%0d required 0 1 0 0",
                         w_valid, blk_ready, w_last, w_round);
                errors++;
            end
            $display("block done at %0t", $time);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        flush     = 1'b0;
        w_ready   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({blk_ready, w_valid, w_t2, w_round, w_choose, w_parity, w_majority, w_cpm, w_last} !== {1'b1, 45'd0}) begin
            $display("FAIL reset_outputs got ready=%b valid=%b t2=%h round=%0d sel=%b%b%b cpm=%b last=%b required ready=1 rest 0",
                     blk_ready, w_valid, w_t2, w_round, w_choose, w_parity, w_majority, w_cpm, w_last);
            errors++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
            $display("FAIL reset_release got ready=%b valid=%b required 1 0", blk_ready, w_valid);
            errors++;
        end
    endtask

    task automatic test_abc();
        logic [511:0] b;
        b = '0;
        b[31:0]    = 32'h61626380;
        b[511:480] = 32'h00000018;
        offer(b);
        checks++;
        if (w_t2 !== 32'hBBE4DD19 || w_choose !== 1'b1) begin
            $display("FAIL abc_t0 got t2=%h choose=%b required BBE4DD19 1", w_t2, w_choose);
            errors++;
        end
        stream_words(b, 0, 15, 1'b0);
        checks++;
        if (w_t2 !== 32'h5A8279B1) begin
            $display("FAIL abc_t15 got=%h required=5A8279B1", w_t2);
            errors++;
        end
        stream_words(b, 15, 16, 1'b0);
        checks++;
        if (w_t2 !== 32'h1D474099) begin
            $display("FAIL abc_t16 got=%h required=1D474099", w_t2);
            errors++;
        end
        stream_words(b, 16, 80, 1'b0);
    endtask

    task automatic test_stall();
        for (int n = 0; n < 2; n++) begin
            logic [511:0] b;
            b = rand_block();
            offer(b);
            stream_words(b, 0, 80, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] a, b;
        a = rand_block();
        b = rand_block();
        offer(a);
        blk_valid = 1'b1;
        blk_data  = b;
        stream_words(a, 0, 80, 1'b0);
        @(negedge clk);
        blk_valid = 1'b0;
        checks++;
        if (w_valid !== 1'b1 || w_round !== 7'd0 || w_t2 !== exp_t2(b, 0)) begin
            $display("FAIL b2b_second_t0 got valid=%b round=%0d t2=%h required 1 0 %h",
                     w_valid, w_round, w_t2, exp_t2(b, 0));
            errors++;
        end
        stream_words(b, 0, 80, 1'b0);
    endtask

    task automatic test_flush();
        logic [511:0] a, c;
        a = rand_block();
        c = rand_block();
        offer(a);
        stream_words(a, 0, 37, 1'b0);
        flush     = 1'b1;
        w_ready   = 1'b1;
        blk_valid = 1'b1;
        blk_data  = c;
        @(negedge clk);
        flush     = 1'b0;
        blk_valid = 1'b0;
        w_ready   = 1'b0;
        checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_round !== 7'd0) begin
            $display("FAIL flush_idle got valid=%b ready=%b round=%0d required 0 1 0",
                     w_valid, blk_ready, w_round);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (w_valid !== 1'b0) begin
            $display("FAIL flush_no_accept got valid=%b required 0", w_valid);
            errors++;
        end
        offer(c);
        stream_words(c, 0, 80, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [511:0] a, c;
        a = rand_block();
        c = rand_block();
        offer(a);
        stream_words(a, 0, 50, 1'b0);
        w_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_round !== 7'd0 || w_t2 !== 32'd0) begin
            $display("FAIL async_reset got valid=%b ready=%b round=%0d t2=%h required 0 1 0 0",
                     w_valid, blk_ready, w_round, w_t2);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin
            $display("FAIL post_reset got valid=%b ready=%b required 0 1", w_valid, blk_ready);
            errors++;
        end
        offer(c);
        stream_words(c, 0, 80, 1'b0);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
